// File: rtl/spi_pkg.sv
// Shared frame geometry and FSM state encoding for the SPI master transmitter.
package spi_pkg;
   localparam int FRAME_W = 12;
   localparam int EDGES   = 2 * FRAME_W;

   typedef enum logic [2:0] {IDLE, ASSERT, XFER, HOLD, DONE} state_t;
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period divider plus edge counter, running only while en is high.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter bit cpol        = 1'b0,
   parameter int HALF_PERIOD = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic lead_edge,
   output logic trail_edge,
   output logic last_edge
);
   localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int EW = $clog2(EDGES + 1);

   logic [HW-1:0] half_cnt;
   logic [EW-1:0] edge_cnt;
   logic          tick;

   // Strobes are combinational so the master acts on the same clock edge that toggles sclk.
   assign tick       = en && (half_cnt == HW'(HALF_PERIOD - 1));
   assign lead_edge  = tick && !edge_cnt[0];
   assign trail_edge = tick &&  edge_cnt[0];
   assign last_edge  = tick && (edge_cnt == EW'(EDGES - 1));

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         half_cnt <= '0;
         edge_cnt <= '0;
         sclk     <= cpol;
      end else if (tick) begin
         half_cnt <= '0;
         edge_cnt <= edge_cnt + 1'b1;
         sclk     <= ~sclk;
      end else begin
         half_cnt <= half_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/spi_master.sv
// Single-frame 12-bit SPI master transmitter with fixed CPOL/CPHA.
// Optional macro SPI_LSB_FIRST_EN sends din[0] first instead of din[11].
module spi_master
   import spi_pkg::*;
#(
   parameter int N           = 4,
   parameter bit cpol        = 1'b0,
   parameter bit cpha        = 1'b0,
   parameter int HALF_PERIOD = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [FRAME_W-1:0] din,
   input  logic [N-1:0]       which_slave_enabled,
   output logic [N-1:0]       cs,
   output logic               mosi,
   output logic               done,
   output logic [FRAME_W-1:0] bits_sent,
   output logic               sclk
);
   localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

   state_t             state;
   logic [FRAME_W-1:0] din_q;
   logic [N-1:0]       sel_q;
   logic [3:0]         bit_cnt;
   logic [HW-1:0]      hold_cnt;
   logic               lead_edge, trail_edge, last_edge;
   logic               sample_edge, shift_edge;

   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign shift_edge  = cpha ? lead_edge  : trail_edge;

   function automatic logic frame_bit(input logic [FRAME_W-1:0] w, input logic [3:0] i);
`ifdef SPI_LSB_FIRST_EN
      return w[i];
`else
      logic [3:0] idx;
      idx = 4'(FRAME_W - 1) - i;
      return w[idx];
`endif
   endfunction

   spi_sclk_gen #(
      .cpol        (cpol),
      .HALF_PERIOD (HALF_PERIOD)
   ) u_sclk_gen (
      .clk        (clk),
      .rst        (rst),
      .en         (state == XFER),
      .sclk       (sclk),
      .lead_edge  (lead_edge),
      .trail_edge (trail_edge),
      .last_edge  (last_edge)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         din_q     <= '0;
         sel_q     <= '0;
         bit_cnt   <= '0;
         hold_cnt  <= '0;
         cs        <= '1;
         mosi      <= 1'b0;
         done      <= 1'b0;
         bits_sent <= '0;
      end else begin
         case (state)
            IDLE: begin
               mosi <= 1'b0;
               if (start) begin
                  din_q     <= din;
                  sel_q     <= which_slave_enabled;
                  bits_sent <= '0;
                  state     <= ASSERT;
               end
            end
            ASSERT: begin
               cs <= ~sel_q;
               // With cpha=0 the first bit must already be on the bus before edge 1 samples it.
               if (!cpha) begin
                  mosi    <= frame_bit(din_q, 4'd0);
                  bit_cnt <= 4'd1;
               end else begin
                  bit_cnt <= 4'd0;
               end
               state <= XFER;
            end
            XFER: begin
               if (sample_edge) begin
`ifdef SPI_LSB_FIRST_EN
                  bits_sent <= {mosi, bits_sent[FRAME_W-1:1]};
`else
                  bits_sent <= {bits_sent[FRAME_W-2:0], mosi};
`endif
               end
               if (shift_edge && (bit_cnt < 4'(FRAME_W))) begin
                  mosi    <= frame_bit(din_q, bit_cnt);
                  bit_cnt <= bit_cnt + 1'b1;
               end
               if (last_edge) begin
                  hold_cnt <= '0;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (hold_cnt == HW'(HALF_PERIOD - 1)) begin
                  cs    <= '1;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            DONE: begin
               if (!start) begin
                  done    <= 1'b0;
                  mosi    <= 1'b0;
                  bit_cnt <= '0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master.sv
// Drives a mode-0 and a mode-3 SPI master in lockstep and checks them against a frame-level model.
module tb_spi_master;
   localparam int N  = 4;
   localparam int HP = 2;
   localparam logic [N-1:0] CS_IDLE = '1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [11:0]   din;
   logic [N-1:0]  sel;

   logic [N-1:0]  cs0, cs3;
   logic          mosi0, mosi3, done0, done3, sclk0, sclk3;
   logic [11:0]   bs0, bs3;

   int tests    = 0;
   int failures = 0;

   logic [0:0] exp_q[$];
   logic [0:0] cap0[$];
   logic [0:0] cap3[$];
   int         viol0, viol3;
   logic       ever_sel;

   logic         ps0 = 1'b0, ps3 = 1'b1, pm0 = 1'b0, pm3 = 1'b0;
   logic [N-1:0] pc0 = '1, pc3 = '1;

   always #5 clk = ~clk;

   spi_master #(.N(N), .cpol(1'b0), .cpha(1'b0), .HALF_PERIOD(HP)) dut0 (
      .clk(clk), .rst(rst), .start(start), .din(din), .which_slave_enabled(sel),
      .cs(cs0), .mosi(mosi0), .done(done0), .bits_sent(bs0), .sclk(sclk0)
   );

   spi_master #(.N(N), .cpol(1'b1), .cpha(1'b1), .HALF_PERIOD(HP)) dut3 (
      .clk(clk), .rst(rst), .start(start), .din(din), .which_slave_enabled(sel),
      .cs(cs3), .mosi(mosi3), .done(done3), .bits_sent(bs3), .sclk(sclk3)
   );

   // Bus monitor: capture mosi at every rising sclk; while selected, mosi may only move on a falling sclk.
   always @(negedge clk) begin
      if (!ps0 && sclk0) cap0.push_back(mosi0);
      if (!ps3 && sclk3) cap3.push_back(mosi3);
      if ((mosi0 !== pm0) && (pc0 != CS_IDLE) && !(ps0 && !sclk0)) viol0++;
      if ((mosi3 !== pm3) && (pc3 != CS_IDLE) && !(ps3 && !sclk3)) viol3++;
      if ((cs0 != CS_IDLE) || (cs3 != CS_IDLE)) ever_sel = 1'b1;
      ps0 = sclk0; ps3 = sclk3; pm0 = mosi0; pm3 = mosi3; pc0 = cs0; pc3 = cs3;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_frame(input logic [11:0] d, input logic [N-1:0] s,
                            input int hold_cycles, input int rst_at_edge);
      int           cyc;
      logic         got;
      logic [N-1:0] exp_cs;
      logic [0:0]   e, c;
      exp_cs = ~s;
      @(posedge clk); #1;
      din = d; sel = s; start = 1'b1;
      cap0.delete(); cap3.delete(); viol0 = 0; viol3 = 0;
      @(posedge clk); #1;
      din = 12'($urandom);
      sel = N'($urandom);
      cyc = 0;
      got = 1'b0;
      while (cyc < 200 && !got) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            check("cs_assert_m0", cs0, exp_cs);
            check("cs_assert_m3", cs3, exp_cs);
         end
         if (rst_at_edge > 0 && cyc == 1 + rst_at_edge * HP) begin
            rst = 1'b1;
            @(posedge clk); #1;
            check("rst_cs_m0", cs0, CS_IDLE);
            check("rst_cs_m3", cs3, CS_IDLE);
            check("rst_sclk_m0", sclk0, 1'b0);
            check("rst_sclk_m3", sclk3, 1'b1);
            check("rst_done_m0", done0, 1'b0);
            check("rst_done_m3", done3, 1'b0);
            check("rst_bits_m0", bs0, 12'h000);
            check("rst_bits_m3", bs3, 12'h000);
            check("rst_mosi_m0", mosi0, 1'b0);
            rst = 1'b0;
            start = 1'b0;
            return;
         end
         if (done0) got = 1'b1;
      end
      check("done_latency", got ? cyc : 0, 1 + 25 * HP);
      check("done_m3", done3, 1'b1);
      check("bits_sent_m0", bs0, d);
      check("bits_sent_m3", bs3, d);
      check("cs_release_m0", cs0, CS_IDLE);
      check("cs_release_m3", cs3, CS_IDLE);
      check("sclk_idle_m0", sclk0, 1'b0);
      check("sclk_idle_m3", sclk3, 1'b1);
      check("mosi_timing_m0", viol0, 0);
      check("mosi_timing_m3", viol3, 0);
      // Expected bus order comes straight from the frame word and the bit-order option.
      for (int i = 0; i < 12; i++) begin
`ifdef SPI_LSB_FIRST_EN
         exp_q.push_back(d[i]);
`else
         exp_q.push_back(d[11-i]);
`endif
      end
      check("cap_count_m0", cap0.size(), 12);
      check("cap_count_m3", cap3.size(), 12);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         c = (cap0.size() > 0) ? cap0.pop_front() : 1'bx;
         check("mosi_bit_m0", c, e);
         c = (cap3.size() > 0) ? cap3.pop_front() : 1'bx;
         check("mosi_bit_m3", c, e);
      end
      if (hold_cycles > 0) begin
         ever_sel = 1'b0;
         repeat (hold_cycles) @(posedge clk);
         #1;
         check("done_held_m0", done0, 1'b1);
         check("done_held_m3", done3, 1'b1);
         check("no_restart", ever_sel, 1'b0);
      end
      start = 1'b0;
      @(posedge clk); #1;
      check("done_fall_m0", done0, 1'b0);
      check("done_fall_m3", done3, 1'b0);
      check("mosi_idle_m0", mosi0, 1'b0);
      check("mosi_idle_m3", mosi3, 1'b0);
      check("bits_hold_m0", bs0, d);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      din = '0;
      sel = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_cs_m0", cs0, CS_IDLE);
      check("reset_cs_m3", cs3, CS_IDLE);
      check("reset_sclk_m0", sclk0, 1'b0);
      check("reset_sclk_m3", sclk3, 1'b1);
      check("reset_mosi_m0", mosi0, 1'b0);
      check("reset_done_m0", done0, 1'b0);
      check("reset_bits_m0", bs0, 12'h000);
      check("reset_bits_m3", bs3, 12'h000);
      rst = 1'b0;

      run_frame(12'hA5C, 4'b0001, 5, 0);
      for (int i = 0; i < 11; i++) begin
         run_frame(12'($urandom), N'(1 << (i % 4)), 0, 0);
      end
      run_frame(12'h3F0, 4'b0100, 0, 0);
      run_frame(12'hF0F, 4'b0010, 0, 10);
      run_frame(12'($urandom_range(0, 4095)), 4'b1000, 0, 0);
      run_frame(12'h001, 4'b1000, 3, 0);
      run_frame(12'($urandom), 4'b0000, 0, 0);
      run_frame(12'($urandom), 4'b0110, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
